// File: rtl/controlador_aes_param_pkg.sv
// Shared AES-128 definitions: FSM states, sizes, Rcon table
// and the forward/common byte-level helpers used by the datapath.
package controlador_aes_param_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KEYEXP,
    INIT,
    ROUND,
    DONE
  } state_t;

  localparam int NR_AES = 10;
  localparam int NRK    = NR_AES + 1;
  localparam int BLK_W  = 128;

  typedef logic [BLK_W-1:0] blk_t;
  typedef blk_t [NRK-1:0]   rks_t;

  localparam logic [9:0][7:0] RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
    8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), with 0 -> 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]}
             ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] x;
    x = {b[6:0], b[7]} ^ {b[4:0], b[7:5]}
      ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(x);
  endfunction

  // Byte i of a block sits at bits [127-8i -: 8]; column c
  // holds bytes 4c..4c+3, row r of column c is byte 4c+r.
  function automatic logic [7:0] bget(
    input blk_t s,
    input int   i
  );
    return s[BLK_W-1-8*i -: 8];
  endfunction

  function automatic blk_t sub_bytes(input blk_t s);
    blk_t r;
    for (int i = 0; i < 16; i++)
      r[BLK_W-1-8*i -: 8] = sbox(bget(s, i));
    return r;
  endfunction

  function automatic blk_t shift_rows(input blk_t s);
    blk_t r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[BLK_W-1-8*(4*c+w) -: 8] = bget(s, 4*((c+w)%4)+w);
    return r;
  endfunction

  function automatic blk_t mix_columns(input blk_t s);
    blk_t r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = bget(s, 4*c);
      a1 = bget(s, 4*c+1);
      a2 = bget(s, 4*c+2);
      a3 = bget(s, 4*c+3);
      r[BLK_W-1-32*c -: 32] = {
        xtime(a0) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ gf_mul(a2, 8'h03) ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ gf_mul(a3, 8'h03),
        gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ xtime(a3)
      };
    end
    return r;
  endfunction

  function automatic blk_t add_round_key(
    input blk_t s,
    input blk_t k
  );
    return s ^ k;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  function automatic rks_t expansion_key(input blk_t k);
    logic [31:0] w [4*NRK];
    logic [31:0] t;
    rks_t rk;
    for (int i = 0; i < 4; i++)
      w[i] = k[BLK_W-1-32*i -: 32];
    for (int i = 4; i < 4*NRK; i++) begin
      t = w[i-1];
      if (i % 4 == 0)
        t = sub_word({t[23:0], t[31:24]})
          ^ {RCON[i/4-1], 24'h000000};
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < NRK; j++)
      rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return rk;
  endfunction

endpackage

// File: rtl/controlador_aes_param_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, key XOR,
// then InvMixColumns unless last. Ports: blk_in, rk, last -> blk_out.
module aes_inv_round
  import controlador_aes_param_pkg::*;
(
  input  logic [127:0] blk_in,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] blk_out
);

  function automatic blk_t inv_shift_rows(input blk_t s);
    blk_t r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[BLK_W-1-8*(4*c+w) -: 8] = bget(s, 4*((c-w+4)%4)+w);
    return r;
  endfunction

  function automatic blk_t inv_sub_bytes(input blk_t s);
    blk_t r;
    for (int i = 0; i < 16; i++)
      r[BLK_W-1-8*i -: 8] = inv_sbox(bget(s, i));
    return r;
  endfunction

  function automatic blk_t inv_mix(input blk_t s);
    blk_t r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = bget(s, 4*c);
      a1 = bget(s, 4*c+1);
      a2 = bget(s, 4*c+2);
      a3 = bget(s, 4*c+3);
      r[BLK_W-1-32*c -: 32] = {
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
          ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
          ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
          ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
          ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
      };
    end
    return r;
  endfunction

  blk_t ark;

  always_comb begin
    ark     = add_round_key(inv_sub_bytes(inv_shift_rows(blk_in)), rk);
    blk_out = last ? ark : inv_mix(ark);
  end

endmodule

// File: rtl/controlador_aes_param.sv
// Iterative AES-128 encrypt/decrypt controller with key-schedule cache.
// Ports: clk, rst, in_valid/in_ready + modo/chave/palavra/limpa_chave,
// out_valid/out_ready + cifra/out_modo, busy.
module controlador_aes_param
  import controlador_aes_param_pkg::*;
#(
  parameter int HAS_DEC   = 1,
  parameter int KEY_CACHE = 1,
  parameter int NR        = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         modo,
  input  logic [127:0] chave,
  input  logic [127:0] palavra,
  input  logic         limpa_chave,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cifra,
  output logic         out_modo,
  output logic         busy
);

  if (NR != NR_AES) begin : g_nr_chk
    $error("controlador_aes_param: NR must be 10 (AES-128)");
  end

  state_t     state;
  blk_t       blk;
  blk_t       key_q;
  blk_t       cache_key;
  logic       cache_valid;
  logic       modo_q;
  rks_t       rk;
  logic [3:0] cnt;

  logic       hit;
  logic       last;
  logic [3:0] dec_idx;
  blk_t       enc_sr;
  blk_t       enc_next;
  blk_t       dec_next;
  blk_t       rnd_next;
  blk_t       init_next;

  assign in_ready = (state == IDLE);

  // A clear on the accept edge forces the miss path.
  assign hit = (KEY_CACHE != 0) && cache_valid && !limpa_chave
             && (chave == cache_key);

  assign last    = (cnt == 4'(NR_AES));
  assign dec_idx = 4'(NR_AES) - cnt;

  assign enc_sr   = shift_rows(sub_bytes(blk));
  assign enc_next = add_round_key(last ? enc_sr : mix_columns(enc_sr),
                                  rk[cnt]);

  if (HAS_DEC != 0) begin : g_dec
    aes_inv_round u_inv (
      .blk_in  (blk),
      .rk      (rk[dec_idx]),
      .last    (last),
      .blk_out (dec_next)
    );
  end else begin : g_nodec
    assign dec_next = '0;
  end

  assign rnd_next  = modo_q ? dec_next : enc_next;
  assign init_next = blk ^ (modo_q ? rk[NR_AES] : rk[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      cifra       <= '0;
      out_modo    <= 1'b0;
      busy        <= 1'b0;
      cnt         <= '0;
      cache_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            blk    <= palavra;
            key_q  <= chave;
            modo_q <= (HAS_DEC != 0) ? modo : 1'b0;
            busy   <= 1'b1;
            state  <= hit ? INIT : KEYEXP;
          end
        end
        KEYEXP: begin
          rk          <= expansion_key(key_q);
          cache_key   <= key_q;
          cache_valid <= 1'b1;
          state       <= INIT;
        end
        INIT: begin
          blk   <= init_next;
          cnt   <= 4'd1;
          state <= ROUND;
        end
        ROUND: begin
          blk <= rnd_next;
          cnt <= cnt + 4'd1;
          if (last) begin
            cifra     <= rnd_next;
            out_modo  <= modo_q;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (limpa_chave) cache_valid <= 1'b0;
    end
  end

endmodule

// File: doc/controlador_aes_param.md
CONTROLADOR_AES_PARAM -- requirements
Module: controlador_aes_param

Interface
REQ-001 SHALL have parameter HAS_DEC, default 1; 1 enables per-request decryption, 0 makes the block encrypt-only.
REQ-002 SHALL have parameter KEY_CACHE, default 1; 1 enables reuse of the last expanded key schedule.
REQ-003 SHALL have parameter NR, default 10; number of AES rounds, fixed at 10 for AES-128; any other value is a parameter error.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 modo  input  1  0 = encrypt, 1 = decrypt; ignored and treated as 0 when HAS_DEC=0.
REQ-009 chave  input  128  cipher key.
REQ-010 palavra  input  128  plaintext or ciphertext block.
REQ-011 limpa_chave  input  1  invalidates the key cache.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 cifra  output  128  result block.
REQ-015 out_modo  output  1  modo of the request that produced cifra.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, KEYEXP, INIT, ROUND, DONE.
REQ-018 in_ready SHALL equal (state==IDLE); a request is accepted on an edge where in_valid and in_ready are both high.
REQ-019 On accept, the block SHALL register palavra, chave and modo.
- Next state is INIT on cache hit (KEY_CACHE=1, cache valid, chave equals the cached key).
- Next state is KEYEXP otherwise.
REQ-020 KEYEXP SHALL last 1 cycle: latch all 11 round keys from the registered key, store the key as the cached key, set the cache valid, then go to INIT.
REQ-021 INIT SHALL last 1 cycle: state <= state XOR rk[0] (encrypt) or rk[NR] (decrypt); round counter <= 1.
REQ-022 Each ROUND cycle SHALL perform one full round on the state.
- Encrypt, counter r: SubBytes, ShiftRows, MixColumns, XOR rk[r].
- Decrypt, counter r: InvShiftRows, InvSubBytes, XOR rk[NR-r], InvMixColumns.
- MixColumns/InvMixColumns are omitted when r==NR.
REQ-023 The counter SHALL increment once per ROUND cycle; after r==NR the FSM goes to DONE.
REQ-024 Latency SHALL be fixed: out_valid rises NR+2 edges after the accept edge on a cache hit and NR+3 edges on a miss.
REQ-025 In DONE, out_valid SHALL be 1, and cifra and out_modo SHALL stay stable until the edge where out_ready is high; then next state is IDLE.
REQ-026 out_valid SHALL be 0 in all states other than DONE; cifra SHALL retain its last result outside DONE.
REQ-027 No request SHALL be accepted while in DONE, even when out_ready is high in that cycle; back-to-back throughput is one block per NR+3 cycles on a cache hit.
REQ-028 limpa_chave high on any edge SHALL clear cache-valid; if it coincides with an accept, that request SHALL be treated as a miss.
REQ-029 in_valid, chave, palavra and modo SHALL be ignored outside IDLE; the registered copies are used for the whole operation.
REQ-030 When KEY_CACHE=0, every request SHALL take the miss path.
REQ-031 The key used for encrypt and for decrypt SHALL be the same cipher key; a cache hit SHALL be valid for either mode.

Reset
REQ-032 On an edge with rst high, the block SHALL set:
- state to IDLE;
- out_valid, cifra, out_modo, busy and the round counter to 0;
- cache-valid to 0.
REQ-033 The reset values of REQ-032 SHALL apply from any state, including mid-KEYEXP and mid-ROUND; the in-flight request is discarded and no out_valid is produced for it.
REQ-034 rst SHALL take priority over all other inputs on the same edge.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding, the AES-128 constants (NR=10, 11 round keys, 128-bit block) and the Rcon table.
REQ-036 The forward datapath SHALL reuse the existing expansion_key, subBytes, shiftrows, mixColumns and AddRoundKey blocks.
REQ-037 A single new sub-module, aes_inv_round, SHALL implement InvShiftRows, InvSubBytes, round-key XOR and optional InvMixColumns; it is instantiated only when HAS_DEC=1.

Verification
REQ-038 FIPS-197 C.1 encrypt: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> cifra 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 13 edges after accept (miss).
REQ-039 Same key, modo=1, palavra 69c4e0d86a7b0430d8cdb78070b4c55a -> cifra 00112233445566778899aabbccddeeff, out_modo=1, latency 12 (hit).
REQ-040 FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; repeat with limpa_chave asserted at accept -> latency 13.
REQ-041 Hold out_ready=0 for 20 cycles after a result -> out_valid stays 1, cifra stable, in_ready stays 0; raise out_ready -> IDLE next edge.
REQ-042 Assert rst during ROUND with counter=5 -> next edge state IDLE, all outputs 0; the next request on the same key takes 13 cycles (cache cleared).
REQ-043 HAS_DEC=0 build with modo=1 and the C.1 vector -> encrypt result 69c4e0d86a7b0430d8cdb78070b4c55a, out_modo=0.
